bin_to_bcd_seq: RTL and testbench

//  Sequential binary-to-BCD encoder (shift-add-3 / double-dabble), one bit per clock.

---
 rtl/bin_to_bcd_seq.sv | 166 ++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD encoder. It converts one input bit per clock.
// Optional macro BCD_HUNDREDS_EN exposes the hundreds digit and raises saturation to 999.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_units,
`ifdef BCD_HUNDREDS_EN
    output logic [3:0]       bcd_hundreds,
`endif
    output logic             ovf
);

    localparam int unsigned ACC_W = 12;
    localparam int unsigned NIB_N = ACC_W / 4;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned CMP_W = 11;
`ifdef BCD_HUNDREDS_EN
    localparam logic [CMP_W-1:0] SAT_LIMIT = CMP_W'(999);
`else
    localparam logic [CMP_W-1:0] SAT_LIMIT = CMP_W'(99);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         units_q, units_d;
    logic               ovf_q, ovf_d;
`ifdef BCD_HUNDREDS_EN
    logic [3:0]         hund_q, hund_d;
`endif

    logic [ACC_W-1:0]   acc_adj_c;
    logic [ACC_W-1:0]   acc_shift_c;

    // Per-nibble add-3 adjust; no carry crosses nibbles, the following shift does that.
    always_comb begin
        acc_adj_c = acc_q;
        for (int i = 0; i < int'(NIB_N); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign acc_shift_c = ACC_W'({acc_adj_c, bin_q[BIN_W-1]});

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        tens_d  = tens_q;
        units_d = units_q;
        ovf_d   = ovf_q;
`ifdef BCD_HUNDREDS_EN
        hund_d  = hund_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    bin_d   = bin_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    // The range test uses the captured value; the 12-bit accumulator cannot show thousands.
                    sat_d   = (CMP_W'(bin_in) > SAT_LIMIT);
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                bin_d  = {bin_q[BIN_W-2:0], 1'b0};
                acc_d  = acc_shift_c;
                cnt_d  = cnt_q - CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (sat_q) begin
                        tens_d  = 4'd9;
                        units_d = 4'd9;
                        ovf_d   = 1'b1;
`ifdef BCD_HUNDREDS_EN
                        hund_d  = 4'd9;
`endif
                    end else begin
                        tens_d  = acc_shift_c[7:4];
                        units_d = acc_shift_c[3:0];
                        ovf_d   = 1'b0;
`ifdef BCD_HUNDREDS_EN
                        hund_d  = acc_shift_c[11:8];
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tens_q  <= '0;
            units_q <= '0;
            ovf_q   <= 1'b0;
`ifdef BCD_HUNDREDS_EN
            hund_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            ovf_q   <= ovf_d;
`ifdef BCD_HUNDREDS_EN
            hund_q  <= hund_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd_tens  = tens_q;
    assign bcd_units = units_q;
    assign ovf       = ovf_q;
`ifdef BCD_HUNDREDS_EN
    assign bcd_hundreds = hund_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq. It uses directed cases and random traffic.
// Each cycle is compared against an arithmetic model of the conversion.
module tb_bin_to_bcd_seq;

    localparam int unsigned BIN_W = 8;
`ifdef BCD_HUNDREDS_EN
    localparam int LIMIT = 999;
`else
    localparam int LIMIT = 99;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_units;
    logic             ovf;
`ifdef BCD_HUNDREDS_EN
    logic [3:0]       bcd_hundreds;
`endif

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy),
        .done      (done),
        .bcd_tens  (bcd_tens),
        .bcd_units (bcd_units),
`ifdef BCD_HUNDREDS_EN
        .bcd_hundreds (bcd_hundreds),
`endif
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: the value in flight, the cycles left until its result, and the last result.
    int m_val  = 0;
    int m_left = 0;
    int m_done = 0;
    int m_h    = 0;
    int m_t    = 0;
    int m_u    = 0;
    int m_ovf  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    function automatic void model_step();
        if (reset) begin
            m_left = 0; m_done = 0;
            m_h = 0; m_t = 0; m_u = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    if (m_val > LIMIT) begin
                        m_ovf = 1; m_h = 9; m_t = 9; m_u = 9;
                    end else begin
                        m_ovf = 0;
                        m_h = (m_val / 100) % 10;
                        m_t = (m_val / 10) % 10;
                        m_u = m_val % 10;
                    end
                end
            end else if (start) begin
                m_val  = int'(bin_in);
                m_left = int'(BIN_W);
            end
        end
    endfunction

    // Advance one clock, update the model, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("busy",  32'(busy),      32'(m_left > 0));
        check("done",  32'(done),      32'(m_done));
        check("tens",  32'(bcd_tens),  32'(m_t));
        check("units", 32'(bcd_units), 32'(m_u));
        check("ovf",   32'(ovf),       32'(m_ovf));
`ifdef BCD_HUNDREDS_EN
        check("hundreds", 32'(bcd_hundreds), 32'(m_h));
`endif
    endtask

    task automatic wait_done(input int bound, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        do begin
            tick();
            n++;
            if (busy && !done) busy_n++;
        end while (!done && n < bound);
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic start_one(input int v);
        bin_in = BIN_W'(v);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    int n, bn, pulses;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("idle_busy",  32'(busy),      32'd0);
        check("idle_done",  32'(done),      32'd0);
        check("idle_tens",  32'(bcd_tens),  32'd0);
        check("idle_units", 32'(bcd_units), 32'd0);
        check("idle_ovf",   32'(ovf),       32'd0);

        // 59: latency and digits
        start_one(59);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(40, n, bn);
        check("latency_59",   32'(n),         32'd8);
        check("busy_cyc_59",  32'(bn),        32'd7);
        check("tens_59",      32'(bcd_tens),  32'd5);
        check("units_59",     32'(bcd_units), 32'd9);
        check("ovf_59",       32'(ovf),       32'd0);
        check("busy_in_done", 32'(busy),      32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("hold_tens_59",   32'(bcd_tens), 32'd5);

        // Back-to-back: 0 then 99 with start held during DONE
        start_one(0);
        wait_done(40, n, bn);
        check("b2b_tens_0",  32'(bcd_tens),  32'd0);
        check("b2b_units_0", 32'(bcd_units), 32'd0);
        bin_in = BIN_W'(99);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("b2b_no_gap", 32'(busy), 32'd1);
        wait_done(40, n, bn);
        check("b2b_latency",  32'(n),         32'd8);
        check("b2b_tens_99",  32'(bcd_tens),  32'd9);
        check("b2b_units_99", 32'(bcd_units), 32'd9);
        tick();

        // 200: saturates unless the hundreds digit is present
        start_one(200);
        wait_done(40, n, bn);
`ifdef BCD_HUNDREDS_EN
        check("hund_200",  32'(bcd_hundreds), 32'd2);
        check("tens_200",  32'(bcd_tens),     32'd0);
        check("units_200", 32'(bcd_units),    32'd0);
        check("ovf_200",   32'(ovf),          32'd0);
`else
        check("tens_200",  32'(bcd_tens),  32'd9);
        check("units_200", 32'(bcd_units), 32'd9);
        check("ovf_200",   32'(ovf),       32'd1);
`endif
        tick();

        // 42 with a stray start of 7 during SHIFT
        start_one(42);
        tick();
        tick();
        bin_in = BIN_W'(7);
        start  = 1'b1;
        tick();
        tick();
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done) pulses++;
        end
        check("ignore_pulses", 32'(pulses),    32'd1);
        check("tens_42",       32'(bcd_tens),  32'd4);
        check("units_42",      32'(bcd_units), 32'd2);

        // Reset four cycles into a conversion of 37
        start_one(37);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_pulses", 32'(pulses),    32'd0);
        check("abort_tens",   32'(bcd_tens),  32'd0);
        check("abort_units",  32'(bcd_units), 32'd0);
        check("abort_busy",   32'(busy),      32'd0);
        start_one(37);
        wait_done(40, n, bn);
        check("tens_37",  32'(bcd_tens),  32'd3);
        check("units_37", 32'(bcd_units), 32'd7);

        // Random traffic with busy-time input churn and rare resets
        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(0, 99) == 0);
            start  = ($urandom_range(0, 2) == 0);
            bin_in = BIN_W'($urandom);
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
